// File: rtl/addr_pkg.sv
// Shared definitions for the adder arbiter: default sizes, FSM encodings,
// and width helpers for the index and watchdog counters.
package addr_pkg;

    localparam int unsigned BIT_DEF  = 8;
    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned TMO_DEF  = 32;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_ABORT = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    // Bits needed to hold a client index 0..n-1 (at least one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bits needed for a watchdog that counts 0..tmo-1.
    function automatic int unsigned wd_width(input int unsigned tmo);
        return (tmo > 1) ? $clog2(tmo) : 1;
    endfunction

endpackage

// File: rtl/addr_arbiter_if.sv
// Client request/response bus plus engine control bus for addr_arbiter.
// master = the arbiter side, slave = clients and engine side.
interface addr_arbiter_if
    import addr_pkg::*;
#(
    parameter int unsigned BIT  = BIT_DEF,
    parameter int unsigned NREQ = NREQ_DEF
);
    logic [NREQ-1:0]     req;
    logic [NREQ*BIT-1:0] req_a;
    logic [NREQ*BIT-1:0] req_b;
    logic [NREQ-1:0]     req_sub;
    logic [NREQ-1:0]     ack;
    logic [BIT-1:0]      res_sum;
    logic                res_cout;
    logic                res_err;
    logic                busy;
    logic                eng_nrst;
    logic                eng_start;
    logic                eng_addsub;
    logic [BIT-1:0]      eng_a;
    logic [BIT-1:0]      eng_b;
    logic [BIT-1:0]      eng_sum;
    logic                eng_cout;
    logic                eng_done;

    modport master (
        input  req, req_a, req_b, req_sub, eng_sum, eng_cout, eng_done,
        output ack, res_sum, res_cout, res_err, busy,
               eng_nrst, eng_start, eng_addsub, eng_a, eng_b
    );

    modport slave (
        output req, req_a, req_b, req_sub, eng_sum, eng_cout, eng_done,
        input  ack, res_sum, res_cout, res_err, busy,
               eng_nrst, eng_start, eng_addsub, eng_a, eng_b
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after ptr,
// wrapping modulo NREQ.
module rr_arbiter
    import addr_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);
    int unsigned   cand;
    logic [IW-1:0] c_idx;

    // Scan from the farthest candidate to the nearest so the nearest one after ptr wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        cand  = 0;
        c_idx = '0;
        any   = |req;
        for (int unsigned k = NREQ; k >= 1; k--) begin
            cand  = (32'(ptr) + k) % NREQ;
            c_idx = IW'(cand);
            if (req[c_idx]) begin
                grant        = '0;
                grant[c_idx] = 1'b1;
                idx          = c_idx;
            end
        end
    end

endmodule

// File: rtl/addr_arbiter.sv
// Round-robin controller sharing one serial add/subtract engine among NREQ
// clients, with a watchdog that aborts and resets a hung engine.
module addr_arbiter
    import addr_pkg::*;
#(
    parameter int unsigned BIT  = BIT_DEF,
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned TMO  = TMO_DEF
) (
    input logic            clk,
    input logic            rst,
    addr_arbiter_if.master bus
);
    localparam int unsigned IW = idx_width(NREQ);
    localparam int unsigned WW = wd_width(TMO);

    logic [2:0]      state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   idx;
    logic [NREQ-1:0] sel;
    logic [WW-1:0]   wd;

    logic [NREQ-1:0] pick_grant;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req   (bus.req),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Engine is held in reset during rst and for the single abort cycle.
    assign bus.eng_nrst = !(rst || (state == S_ABORT));

    // Transaction FSM, watchdog, operand latches and registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            ptr            <= IW'(NREQ - 1);
            idx            <= '0;
            sel            <= '0;
            wd             <= '0;
            bus.ack        <= '0;
            bus.res_sum    <= '0;
            bus.res_cout   <= 1'b0;
            bus.res_err    <= 1'b0;
            bus.busy       <= 1'b0;
            bus.eng_start  <= 1'b0;
            bus.eng_addsub <= 1'b0;
            bus.eng_a      <= '0;
            bus.eng_b      <= '0;
        end else begin
            bus.ack       <= '0;
            bus.res_sum   <= '0;
            bus.res_cout  <= 1'b0;
            bus.res_err   <= 1'b0;
            bus.eng_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_any) begin
                        idx            <= pick_idx;
                        sel            <= pick_grant;
                        bus.eng_a      <= bus.req_a[pick_idx*BIT +: BIT];
                        bus.eng_b      <= bus.req_b[pick_idx*BIT +: BIT];
                        bus.eng_addsub <= bus.req_sub[pick_idx];
                        bus.eng_start  <= 1'b1;
                        bus.busy       <= 1'b1;
                        state          <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wd    <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // A done arriving on the expiry cycle still completes normally.
                    if (bus.eng_done) begin
                        bus.res_sum  <= bus.eng_sum;
                        bus.res_cout <= bus.eng_cout;
                        bus.ack      <= sel;
                        state        <= S_RESP;
                    end else if (wd == WW'(TMO - 1)) begin
                        state <= S_ABORT;
                    end else begin
                        wd <= wd + WW'(1);
                    end
                end
                S_ABORT: begin
                    bus.res_err <= 1'b1;
                    bus.ack     <= sel;
                    state       <= S_RESP;
                end
                S_RESP: begin
                    ptr      <= idx;
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addr_arbiter.sv
// Bench for addr_arbiter: serial engine model, transaction-level reference
// model, per-cycle compare, directed scenarios and a randomized phase.
module tb_addr_arbiter;
    import addr_pkg::*;

    localparam int unsigned BIT  = 8;
    localparam int unsigned NREQ = 4;
    localparam int unsigned TMO  = 32;
    localparam int unsigned EW   = $clog2(BIT);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hang = 1'b0;
    logic spur = 1'b0;
    logic rnd_en = 1'b0;
    logic [NREQ-1:0] hold_mask = '0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int             idx;
        logic [BIT-1:0] sum;
        logic           cout;
        logic           err;
    } ack_t;
    ack_t log_q[$];

    int busy_total = 0;
    int start_total = 0;
    int nrst_low_total = 0;

    always #5 clk = ~clk;

    addr_arbiter_if #(.BIT(BIT), .NREQ(NREQ)) bus ();

    addr_arbiter #(.BIT(BIT), .NREQ(NREQ), .TMO(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Serial engine: one bit per cycle after start, done pulse after BIT bits.
    logic [BIT-1:0] e_a, e_b;
    logic           e_run = 1'b0;
    logic           e_fin;
    logic [EW-1:0]  e_bit;
    always @(posedge clk) begin
        e_fin = 1'b0;
        if (!bus.eng_nrst) begin
            e_run <= 1'b0;
        end else if (bus.eng_start) begin
            e_a          <= bus.eng_a;
            e_b          <= bus.eng_addsub ? ~bus.eng_b : bus.eng_b;
            bus.eng_cout <= bus.eng_addsub;
            e_bit        <= '0;
            e_run        <= 1'b1;
        end else if (e_run && !hang) begin
            bus.eng_sum[e_bit] <= e_a[e_bit] ^ e_b[e_bit] ^ bus.eng_cout;
            bus.eng_cout <= (e_a[e_bit] & e_b[e_bit]) | (bus.eng_cout & (e_a[e_bit] ^ e_b[e_bit]));
            e_bit <= e_bit + 1'b1;
            if (e_bit == EW'(BIT - 1)) begin
                e_run <= 1'b0;
                e_fin = 1'b1;
            end
        end
        bus.eng_done <= e_fin | spur;
    end

    // Reference model: stage 0 idle, 1 start issued, 2 waiting, 3 aborting, 4 responding.
    int             m_stage = 0;
    int             m_ptr = NREQ - 1;
    int             m_idx = 0;
    int             m_wd = 0;
    int             m_c;
    logic           m_found;
    logic [BIT-1:0] m_a = '0, m_b = '0, m_sum = '0;
    logic           m_sub = 1'b0, m_cout = 1'b0, m_err = 1'b0;
    logic [NREQ-1:0] m_ack = '0;
    int             m_pass[NREQ] = '{default: 0};
    int             m_max_pass = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_stage = 0; m_ptr = NREQ - 1; m_wd = 0;
            m_a = '0; m_b = '0; m_sub = 1'b0;
            m_ack = '0; m_sum = '0; m_cout = 1'b0; m_err = 1'b0;
            for (int j = 0; j < NREQ; j++) m_pass[j] = 0;
        end else begin
            m_ack = '0; m_sum = '0; m_cout = 1'b0; m_err = 1'b0;
            if (m_stage == 0) begin
                m_found = 1'b0;
                for (int k = 1; k <= NREQ; k++) begin
                    m_c = (m_ptr + k) % NREQ;
                    if (!m_found && bus.req[m_c]) begin
                        m_found = 1'b1;
                        m_idx = m_c;
                    end
                end
                if (m_found) begin
                    m_a = bus.req_a[m_idx*BIT +: BIT];
                    m_b = bus.req_b[m_idx*BIT +: BIT];
                    m_sub = bus.req_sub[m_idx];
                    m_max_pass = 0;
                    for (int j = 0; j < NREQ; j++) begin
                        if (j == m_idx || !bus.req[j]) m_pass[j] = 0;
                        else m_pass[j]++;
                        if (m_pass[j] > m_max_pass) m_max_pass = m_pass[j];
                    end
                    m_stage = 1;
                end
            end else if (m_stage == 1) begin
                m_wd = 0;
                m_stage = 2;
            end else if (m_stage == 2) begin
                if (bus.eng_done) begin
                    m_ack[m_idx] = 1'b1;
                    m_sum = m_sub ? BIT'(m_a - m_b) : BIT'(m_a + m_b);
                    m_cout = m_sub ? (m_a >= m_b) : ((int'(m_a) + int'(m_b)) >= (1 << BIT));
                    m_stage = 4;
                end else if (m_wd == TMO - 1) begin
                    m_stage = 3;
                end else begin
                    m_wd++;
                end
            end else if (m_stage == 3) begin
                m_ack[m_idx] = 1'b1;
                m_err = 1'b1;
                m_stage = 4;
            end else begin
                m_ptr = m_idx;
                m_stage = 0;
            end
        end
    end

    // Per-cycle compare of every DUT output against the model, plus ack logging.
    always @(posedge clk) begin
        #1;
        chk("busy", 32'(bus.busy), 32'(m_stage != 0));
        chk("eng_start", 32'(bus.eng_start), 32'(m_stage == 1));
        chk("eng_nrst", 32'(bus.eng_nrst), 32'(!rst && m_stage != 3));
        chk("eng_a", 32'(bus.eng_a), 32'(m_a));
        chk("eng_b", 32'(bus.eng_b), 32'(m_b));
        chk("eng_addsub", 32'(bus.eng_addsub), 32'(m_sub));
        chk("ack", 32'(bus.ack), 32'(m_ack));
        chk("res_sum", 32'(bus.res_sum), 32'(m_sum));
        chk("res_cout", 32'(bus.res_cout), 32'(m_cout));
        chk("res_err", 32'(bus.res_err), 32'(m_err));
        if (m_stage == 1) chk("fairness", 32'(m_max_pass < NREQ), 32'd1);
        if (bus.busy) busy_total++;
        if (bus.eng_start) start_total++;
        if (!bus.eng_nrst && !rst) nrst_low_total++;
        if (bus.ack != '0) begin
            ack_t e;
            e.idx = -1;
            for (int j = 0; j < NREQ; j++) if (bus.ack[j]) e.idx = j;
            e.sum = bus.res_sum;
            e.cout = bus.res_cout;
            e.err = bus.res_err;
            log_q.push_back(e);
        end
    end

    // Requester behaviour: drop on ack, re-raise held or random requests.
    task automatic cycle();
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (bus.ack[i]) begin
                bus.req[i] = 1'b0;
            end else if (!bus.req[i] && (hold_mask[i] || (rnd_en && $urandom_range(0, 3) == 0))) begin
                if (rnd_en) begin
                    bus.req_a[i*BIT +: BIT] = BIT'($urandom);
                    bus.req_b[i*BIT +: BIT] = BIT'($urandom);
                    bus.req_sub[i] = 1'($urandom);
                end
                bus.req[i] = 1'b1;
            end
        end
        if (rnd_en && m_stage != 0 && $urandom_range(0, 7) == 0)
            bus.req_a[m_idx*BIT +: BIT] = BIT'($urandom);
    endtask

    task automatic set_op(input int i, input logic [BIT-1:0] a, input logic [BIT-1:0] b, input logic sub);
        bus.req_a[i*BIT +: BIT] = a;
        bus.req_b[i*BIT +: BIT] = b;
        bus.req_sub[i] = sub;
    endtask

    task automatic raise(input int i, input logic [BIT-1:0] a, input logic [BIT-1:0] b, input logic sub);
        cycle();
        set_op(i, a, b, sub);
        bus.req[i] = 1'b1;
    endtask

    task automatic wait_acks(input int n, input int budget);
        int b = 0;
        while (log_q.size() < n && b < budget) begin
            cycle();
            b++;
        end
        chk("ack_wait", 32'(log_q.size() >= n), 32'd1);
    endtask

    task automatic drain(input int budget);
        int b = 0;
        while ((bus.req != '0 || bus.busy) && b < budget) begin
            cycle();
            b++;
        end
        chk("drain", 32'(bus.req == '0 && !bus.busy), 32'd1);
    endtask

    task automatic chk_ack(input string nm, input int k, input int idx,
                           input logic [BIT-1:0] sum, input logic cout, input logic err);
        if (k < log_q.size()) begin
            chk({nm, "_idx"}, 32'(log_q[k].idx), 32'(idx));
            chk({nm, "_sum"}, 32'(log_q[k].sum), 32'(sum));
            chk({nm, "_cout"}, 32'(log_q[k].cout), 32'(cout));
            chk({nm, "_err"}, 32'(log_q[k].err), 32'(err));
        end else begin
            chk({nm, "_missing"}, 32'(log_q.size()), 32'(k + 1));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n0, b0, s0, r0;
        bus.req = '0; bus.req_a = '0; bus.req_b = '0; bus.req_sub = '0;
        repeat (3) cycle();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_nrst", 32'(bus.eng_nrst), 32'd0);
        chk("rst_eng_a", 32'(bus.eng_a), 32'd0);
        rst = 1'b0;
        cycle();
        chk("idle_nrst", 32'(bus.eng_nrst), 32'd1);

        // Single add.
        n0 = log_q.size(); b0 = busy_total; s0 = start_total;
        raise(0, 8'h25, 8'h13, 1'b0);
        wait_acks(n0 + 1, 100);
        repeat (3) cycle();
        chk_ack("add", n0, 0, 8'h38, 1'b0, 1'b0);
        chk("add_one_ack", 32'(log_q.size() - n0), 32'd1);
        chk("add_busy_cycles", 32'(busy_total - b0), 32'd11);
        chk("add_start_cycles", 32'(start_total - s0), 32'd1);

        // Subtracts.
        n0 = log_q.size();
        raise(1, 8'h10, 8'h01, 1'b1);
        wait_acks(n0 + 1, 100);
        raise(1, 8'h01, 8'h02, 1'b1);
        wait_acks(n0 + 2, 100);
        chk_ack("sub_pos", n0, 1, 8'h0F, 1'b1, 1'b0);
        chk_ack("sub_neg", n0 + 1, 1, 8'hFF, 1'b0, 1'b0);

        // All four at once, pointer left at 1 -> 2,3,0,1; reset pointer first via rst.
        cycle();
        rst = 1'b1; cycle(); rst = 1'b0; cycle();
        n0 = log_q.size();
        for (int i = 0; i < NREQ; i++) set_op(i, BIT'(i * 16 + 1), BIT'(i + 2), 1'b0);
        bus.req = '1;
        wait_acks(n0 + 4, 200);
        for (int i = 0; i < NREQ; i++)
            chk_ack("all4", n0 + i, i, BIT'(i * 16 + 1 + i + 2), 1'b0, 1'b0);

        // Clients 0 and 2 held continuously alternate.
        drain(100);
        n0 = log_q.size();
        set_op(0, 8'h01, 8'h01, 1'b0);
        set_op(2, 8'h02, 8'h02, 1'b0);
        hold_mask = 4'b0101;
        wait_acks(n0 + 4, 200);
        hold_mask = '0;
        drain(100);
        chk_ack("alt0", n0, 0, 8'h02, 1'b0, 1'b0);
        chk_ack("alt1", n0 + 1, 2, 8'h04, 1'b0, 1'b0);
        chk_ack("alt2", n0 + 2, 0, 8'h02, 1'b0, 1'b0);
        chk_ack("alt3", n0 + 3, 2, 8'h04, 1'b0, 1'b0);

        // Hung engine -> watchdog abort, then a normal transaction.
        hang = 1'b1;
        n0 = log_q.size(); b0 = busy_total; r0 = nrst_low_total;
        raise(0, 8'h11, 8'h22, 1'b0);
        wait_acks(n0 + 1, 100);
        chk_ack("abort", n0, 0, 8'h00, 1'b0, 1'b1);
        chk("abort_busy_cycles", 32'(busy_total - b0), 32'd35);
        chk("abort_nrst_cycles", 32'(nrst_low_total - r0), 32'd1);
        hang = 1'b0;
        raise(0, 8'h01, 8'h01, 1'b0);
        wait_acks(n0 + 2, 100);
        chk_ack("after_abort", n0 + 1, 0, 8'h02, 1'b0, 1'b0);

        // Reset during WAIT.
        raise(1, 8'h33, 8'h44, 1'b0);
        repeat (5) cycle();
        n0 = log_q.size();
        rst = 1'b1;
        cycle();
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_ack", 32'(bus.ack), 32'd0);
        chk("midrst_nrst", 32'(bus.eng_nrst), 32'd0);
        bus.req[1] = 1'b0;
        rst = 1'b0;
        repeat (2) cycle();
        chk("midrst_no_ack", 32'(log_q.size() - n0), 32'd0);
        cycle();
        set_op(0, 8'h05, 8'h03, 1'b1);
        set_op(3, 8'h80, 8'h80, 1'b0);
        bus.req[0] = 1'b1;
        bus.req[3] = 1'b1;
        wait_acks(n0 + 2, 100);
        chk_ack("post_rst0", n0, 0, 8'h02, 1'b1, 1'b0);
        chk_ack("post_rst3", n0 + 1, 3, 8'h00, 1'b1, 1'b0);

        // Spurious done while idle, then operand change after grant.
        drain(100);
        n0 = log_q.size();
        spur = 1'b1;
        cycle();
        spur = 1'b0;
        repeat (4) cycle();
        chk("spur_no_ack", 32'(log_q.size() - n0), 32'd0);
        chk("spur_idle", 32'(bus.busy), 32'd0);
        raise(2, 8'h40, 8'h05, 1'b0);
        repeat (2) cycle();
        bus.req_a[2*BIT +: BIT] = 8'hFF;
        wait_acks(n0 + 1, 100);
        chk_ack("latched_ops", n0, 2, 8'h45, 1'b0, 1'b0);

        // Randomized traffic checked cycle by cycle against the model.
        rnd_en = 1'b1;
        repeat (3000) cycle();
        rnd_en = 1'b0;
        drain(500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
